// File: rtl/wdt_multi_ch.sv
// Multi-channel watchdog: one shared slow tick, per-channel kick/enable/timeout,
// pre-timeout warning, registered timeout and sticky expiry flag.
module wdt_multi_ch #(
  parameter int CH_NUM      = 4,
  parameter int CNT_W       = 10,
  parameter int WARN_MARGIN = 2,
  parameter int AUTO_REARM  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_tick,
  input  logic [CH_NUM-1:0]       i_kick,
  input  logic [CH_NUM-1:0]       i_en,
  input  logic [CH_NUM*CNT_W-1:0] i_timeout,
  input  logic [CH_NUM-1:0]       i_sticky_clr,
  output logic [CH_NUM-1:0]       o_warn,
  output logic [CH_NUM-1:0]       o_timeout,
  output logic [CH_NUM-1:0]       o_timeout_sticky,
  output logic                    o_timeout_any
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, EXPIRED = 2'd2} state_t;

  logic              tick_s1, tick_s2, tick_d, tick_p;
  logic [CH_NUM-1:0] kick_s1, kick_s2, kick_d, kick_p;
  logic [CH_NUM-1:0] warn_n, expired_n, sticky_set;

  // Synchronisers reset high so an input already high at release is not an edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_s1 <= 1'b1;
      tick_s2 <= 1'b1;
      tick_d  <= 1'b1;
      kick_s1 <= '1;
      kick_s2 <= '1;
      kick_d  <= '1;
    end else begin
      tick_s1 <= i_tick;
      tick_s2 <= tick_s1;
      tick_d  <= tick_s2;
      kick_s1 <= i_kick;
      kick_s2 <= kick_s1;
      kick_d  <= kick_s2;
    end
  end

  assign tick_p = tick_s2 & ~tick_d;
  assign kick_p = kick_s2 & ~kick_d;

  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, to, thr;
    logic [CNT_W:0]   cnt_inc;

    assign to      = i_timeout[n*CNT_W +: CNT_W];
    assign thr     = (to > CNT_W'(WARN_MARGIN)) ? (to - CNT_W'(WARN_MARGIN)) : '0;
    assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);

    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      if (!i_en[n] || (to == '0)) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        case (state)
          IDLE: begin
            state_n = RUN;
            cnt_n   = '0;
          end
          RUN: begin
            if (kick_p[n]) begin
              cnt_n = '0;
            end else if (tick_p) begin
              // Live compare: a timeout lowered below the count expires, never wraps
              if (cnt_inc >= {1'b0, to}) begin
                state_n = EXPIRED;
                cnt_n   = to;
              end else begin
                cnt_n = cnt_inc[CNT_W-1:0];
              end
            end
          end
          EXPIRED: begin
            if ((AUTO_REARM != 0) && kick_p[n]) begin
              state_n = RUN;
              cnt_n   = '0;
            end
          end
          default: begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        endcase
      end
    end

    assign warn_n[n]     = (state_n == RUN) && (cnt_n >= thr);
    assign expired_n[n]  = (state_n == EXPIRED);
    assign sticky_set[n] = (state == RUN) && (state_n == EXPIRED);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= state_n;
        cnt   <= cnt_n;
      end
    end
  end

  // Outputs registered from next state so they align with the state change
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_warn           <= '0;
      o_timeout        <= '0;
      o_timeout_sticky <= '0;
      o_timeout_any    <= 1'b0;
    end else begin
      o_warn           <= warn_n;
      o_timeout        <= expired_n;
      o_timeout_sticky <= sticky_set | (o_timeout_sticky & ~i_sticky_clr);
      o_timeout_any    <= |expired_n;
    end
  end

endmodule
